uart_prog_loader: RTL and testbench
===================================

# uart_prog_loader

Upstream stage of `cpu_uart_top`: receives the program image over the serial line (8N1) and assembles little-endian 32-bit words. Writes the words into instruction memory at consecutive cell addresses and holds the CPU in reset until all `CELL_NUMBERS` cells are loaded. Releasing the CPU is the hand-off point at which instruction execution begins.

## Interface
Parameters:
- `CLKS_PER_BIT`, 4: clock cycles per UART bit; must be ≥ 4 and even.
- `CELL_NUMBERS`, 64: number of 32-bit instruction cells to load.
- `ADDR_W`, `$clog2(CELL_NUMBERS)`: width of the word address.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `rx`  in  1  asynchronous serial input; idles high.
- `imem_we`  out  1  one-cycle write strobe to instruction memory.
- `imem_addr`  out  `ADDR_W`  word index of the write.
- `imem_wdata`  out  32  assembled instruction word.
- `load_done`  out  1  sticky; all cells written.
- `cpu_rst`  out  1  reset to the CPU core; equals `rst | ~load_done`, registered.
- `frame_err`  out  1  sticky; a stop bit was sampled low.

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 1.
- RX FSM states:
  - IDLE: wait for synchronized `rx`=0.
  - START: count `CLKS_PER_BIT/2`. If `rx` is still 0, go to DATA; if it is 1 (glitch), return to IDLE.
  - DATA: sample 8 bits, each `CLKS_PER_BIT` cycles apart (mid-bit), LSB first.
  - STOP: sample after `CLKS_PER_BIT`. If the sample is 1, pulse `byte_valid` for one cycle. If it is 0, set `frame_err` and drop the byte.
  - STOP returns to IDLE in both cases.
- Loader:
  - A 2-bit byte counter selects the byte lane. Byte k goes to `wdata[8k+7:8k]`, so the first byte received is the LSB.
  - When the 4th valid byte arrives: `imem_we`=1 for one cycle, `imem_addr` = word counter, then increment the word counter and clear the byte counter.
  - When the word counter reaches `CELL_NUMBERS`, set `load_done`. After that, all further bytes are ignored and `imem_we` never pulses again.
- Dropped (framing-error) bytes do not advance the byte counter.
- Reset mid-load: all counters, the partial word and the sticky flags are cleared, and the RX FSM returns to IDLE. The next load starts at address 0.

## Timing
- Reset values: `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `load_done`=0, `cpu_rst`=1, `frame_err`=0.
- Latency from `rx` edge to FSM input: 2 cycles.
- `byte_valid` fires at the stop-bit mid-sample, (9.5·`CLKS_PER_BIT`)+2 cycles after the start edge.
- `imem_we` is high in the cycle after the 4th `byte_valid`. `imem_addr` and `imem_wdata` are valid in that same cycle only.
- `load_done` rises in the cycle after the final `imem_we`. `cpu_rst` falls one cycle later.
- The word counter is `ADDR_W+1` bits wide, so no wrap-around occurs. `imem_addr` is its low `ADDR_W` bits.
- A new start bit received during the stop-bit sample cycle is not lost: the FSM re-enters IDLE and detects it on the next cycle.

## Structure
- Shared package `loader_pkg`: RX state enum (`RX_IDLE`, `RX_START`, `RX_DATA`, `RX_STOP`) and the default `CLKS_PER_BIT` constant.
- Sub-module `uart_rx_byte`:
  - Contains the synchronizer, RX FSM and baud counter.
  - Outputs `byte_valid`, `byte_data[7:0]` and `frame_err_pulse`.
- Top level: word assembly, counters and CPU reset gating.

## Test plan
- `CLKS_PER_BIT`=4, `CELL_NUMBERS`=2. Send bytes 13 05 10 00, then 93 05 20 00 → `imem_we` at addr 0 with 0x00100513, then at addr 1 with 0x00200593. `load_done`=1, `frame_err`=0, and `cpu_rst` falls 1 cycle after `load_done`.
- Send the same 8 bytes plus an extra byte 0xFF → no third `imem_we`; `load_done` stays 1.
- Send byte 0x13 with the stop bit forced low, then the valid stream 13 05 10 00 → `frame_err`=1 and word 0 = 0x00100513; the bad byte is not counted.
- Pulse `rx` low for 1 cycle only → RX FSM returns to IDLE with no `byte_valid` and no error.
- Send 2 bytes, assert `rst` for 1 cycle, then send the full 8-byte stream → first write at addr 0 with 0x00100513; all outputs held at reset values during `rst`.
- Send back-to-back bytes with no idle time between stop and start → all 8 bytes captured correctly.

Source files
------------

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and defaults for the UART program loader
package loader_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 4;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 receiver: synchronizer, baud counter and RX FSM
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err_pulse
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

  logic          rx_meta;
  logic          rx_sync;
  rx_state_e     state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta         <= 1'b1;
      rx_sync         <= 1'b1;
      state           <= RX_IDLE;
      baud_cnt        <= '0;
      bit_idx         <= '0;
      shift           <= '0;
      byte_valid      <= 1'b0;
      byte_data       <= '0;
      frame_err_pulse <= 1'b0;
    end else begin
      rx_meta         <= rx;
      rx_sync         <= rx_meta;
      byte_valid      <= 1'b0;
      frame_err_pulse <= 1'b0;
      case (state)
        RX_IDLE: begin
          baud_cnt <= '0;
          if (!rx_sync) state <= RX_START;
        end
        // Half a bit in, re-check the line so a short glitch is not taken as a start bit.
        RX_START: begin
          if (baud_cnt == HALF_CNT) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (baud_cnt == FULL_CNT) begin
            baud_cnt <= '0;
            shift    <= {rx_sync, shift[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (baud_cnt == FULL_CNT) begin
            baud_cnt <= '0;
            state    <= RX_IDLE;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              byte_data  <= shift;
            end else begin
              frame_err_pulse <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - assembles UART bytes into words, fills imem, gates CPU reset
module uart_prog_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CELL_NUMBERS = 64,
  parameter int ADDR_W       = $clog2(CELL_NUMBERS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              load_done,
  output logic              cpu_rst,
  output logic              frame_err
);

  localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W + 1)'(CELL_NUMBERS);

  logic            byte_valid;
  logic [7:0]      byte_data;
  logic            frame_err_pulse;
  logic [1:0]      byte_cnt;
  logic [23:0]     word_buf;
  logic [ADDR_W:0] word_cnt;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk            (clk),
    .rst            (rst),
    .rx             (rx),
    .byte_valid     (byte_valid),
    .byte_data      (byte_data),
    .frame_err_pulse(frame_err_pulse)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt   <= '0;
      word_buf   <= '0;
      word_cnt   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      load_done  <= 1'b0;
      cpu_rst    <= 1'b1;
      frame_err  <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      cpu_rst <= ~load_done;
      if (frame_err_pulse) frame_err <= 1'b1;
      if (word_cnt == LAST_WORD) load_done <= 1'b1;
      // Bytes arriving once the image is complete are discarded.
      if (byte_valid && !load_done && word_cnt != LAST_WORD) begin
        case (byte_cnt)
          2'd0: word_buf[7:0]   <= byte_data;
          2'd1: word_buf[15:8]  <= byte_data;
          2'd2: word_buf[23:16] <= byte_data;
          default: begin
            imem_we    <= 1'b1;
            imem_addr  <= word_cnt[ADDR_W-1:0];
            imem_wdata <= {byte_data, word_buf};
            word_cnt   <= word_cnt + (ADDR_W + 1)'(1);
          end
        endcase
        byte_cnt <= byte_cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - scoreboard bench for uart_prog_loader
module tb_uart_prog_loader;

  localparam int CPB = 4;
  localparam int CELLS = 2;
  localparam int AW = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx = 1'b1;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          load_done;
  logic          cpu_rst;
  logic          frame_err;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int          nb;
    logic [79:0] bytes;
    logic [9:0]  bad;
    int          gap;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        ferr;
    logic        done;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[5];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   we_cyc = -1;
  int   done_cyc = -1;
  int   cpu_fall_cyc = -1;
  logic prev_we = 1'b0;
  logic prev_done = 1'b0;
  logic prev_cpu_rst = 1'b1;

  uart_prog_loader #(
    .CLKS_PER_BIT(CPB),
    .CELL_NUMBERS(CELLS),
    .ADDR_W      (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .load_done (load_done),
    .cpu_rst   (cpu_rst),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (imem_we) begin
      we_cyc = cyc;
      check("we_pulse_width", {31'd0, prev_we}, 32'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %h expected no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", {31'd0, imem_addr}, e.addr);
        check("write_data", imem_wdata, e.data);
      end
    end
    if (load_done && !prev_done) done_cyc = cyc;
    if (!cpu_rst && prev_cpu_rst) cpu_fall_cyc = cyc;
    prev_we = imem_we;
    prev_done = load_done;
    prev_cpu_rst = cpu_rst;
  end

  task automatic wait_cycles(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_ok, input int gap);
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cycles(CPB);
    end
    rx = stop_ok;
    wait_cycles(CPB);
    rx = 1'b1;
    wait_cycles(gap);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, {31'd0, imem_we}, 32'd0);
    check({tag, "_addr"}, {31'd0, imem_addr}, 32'd0);
    check({tag, "_wdata"}, imem_wdata, 32'd0);
    check({tag, "_load_done"}, {31'd0, load_done}, 32'd0);
    check({tag, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
    check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
  endtask

  task automatic do_reset();
    rx = 1'b1;
    rst = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(2);
  endtask

  task automatic push_stream8();
    exp_q.push_back('{addr: 32'd0, data: 32'h00100513});
    exp_q.push_back('{addr: 32'd1, data: 32'h00200593});
  endtask

  task automatic send_stream8(input int gap);
    logic [63:0] s;
    s = 64'h0020_0593_0010_0513;
    for (int i = 0; i < 8; i++) send_byte(s[8*i +: 8], 1'b1, gap);
  endtask

  initial begin
    vecs[0] = '{nb: 8, bytes: 80'h0020_0593_0010_0513, bad: 10'h000, gap: 8, nw: 2,
                w0: 32'h00100513, w1: 32'h00200593, ferr: 1'b0, done: 1'b1};
    vecs[1] = '{nb: 9, bytes: 80'hFF_0020_0593_0010_0513, bad: 10'h000, gap: 8, nw: 2,
                w0: 32'h00100513, w1: 32'h00200593, ferr: 1'b0, done: 1'b1};
    vecs[2] = '{nb: 5, bytes: 80'h00_1005_1313, bad: 10'h001, gap: 8, nw: 1,
                w0: 32'h00100513, w1: 32'h0, ferr: 1'b1, done: 1'b0};
    vecs[3] = '{nb: 8, bytes: 80'h0020_0593_0010_0513, bad: 10'h000, gap: 0, nw: 2,
                w0: 32'h00100513, w1: 32'h00200593, ferr: 1'b0, done: 1'b1};
    vecs[4] = '{nb: 8, bytes: 80'h0403_0201_FF00_55AA, bad: 10'h000, gap: 4, nw: 2,
                w0: 32'hFF0055AA, w1: 32'h04030201, ferr: 1'b0, done: 1'b1};

    rst = 1'b1;
    wait_cycles(3);
    check_reset_outputs("por");
    rst = 1'b0;
    wait_cycles(2);

    // One-cycle low glitch must not produce a byte or an error.
    rx = 1'b0;
    wait_cycles(1);
    rx = 1'b1;
    wait_cycles(20);
    exp_q.push_back('{addr: 32'd0, data: 32'h00100513});
    send_byte(8'h13, 1'b1, 8);
    send_byte(8'h05, 1'b1, 8);
    send_byte(8'h10, 1'b1, 8);
    send_byte(8'h00, 1'b1, 8);
    wait_cycles(20);
    check("glitch_pending_writes", exp_q.size(), 32'd0);
    check("glitch_frame_err", {31'd0, frame_err}, 32'd0);
    check("glitch_load_done", {31'd0, load_done}, 32'd0);

    // Partial word, then a one-cycle reset: loading restarts at address 0.
    send_byte(8'h13, 1'b1, 8);
    send_byte(8'h05, 1'b1, 8);
    rst = 1'b1;
    wait_cycles(1);
    check_reset_outputs("midrst");
    rst = 1'b0;
    wait_cycles(4);
    push_stream8();
    send_stream8(8);
    wait_cycles(20);
    check("midrst_pending_writes", exp_q.size(), 32'd0);
    check("midrst_load_done", {31'd0, load_done}, 32'd1);
    check("midrst_cpu_rst", {31'd0, cpu_rst}, 32'd0);

    for (int v = 0; v < 5; v++) begin
      do_reset();
      we_cyc = -1;
      done_cyc = -1;
      cpu_fall_cyc = -1;
      if (vecs[v].nw > 0) exp_q.push_back('{addr: 32'd0, data: vecs[v].w0});
      if (vecs[v].nw > 1) exp_q.push_back('{addr: 32'd1, data: vecs[v].w1});
      for (int i = 0; i < vecs[v].nb; i++)
        send_byte(vecs[v].bytes[8*i +: 8], ~vecs[v].bad[i],
                  vecs[v].bad[i] ? 2 * CPB : vecs[v].gap);
      wait_cycles(30);
      check($sformatf("v%0d_pending_writes", v), exp_q.size(), 32'd0);
      check($sformatf("v%0d_frame_err", v), {31'd0, frame_err}, {31'd0, vecs[v].ferr});
      check($sformatf("v%0d_load_done", v), {31'd0, load_done}, {31'd0, vecs[v].done});
      check($sformatf("v%0d_cpu_rst", v), {31'd0, cpu_rst}, {31'd0, ~vecs[v].done});
      if (vecs[v].done) begin
        check($sformatf("v%0d_done_after_we", v), done_cyc - we_cyc, 32'd1);
        check($sformatf("v%0d_cpu_fall_after_done", v), cpu_fall_cyc - done_cyc, 32'd1);
      end
      exp_q.delete();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
